// File: rtl/ex_memory_access_unit.sv
// Execute-stage memory access unit: loads, stores, LR/SC and AMO read-modify-write
// over a valid/ready data port, with ID/EX stall generation and an LR/SC reservation.
module ex_memory_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_mem_op_length,
    input  logic [4:0]            ex_atomic_op,
    input  logic [ADDR_WIDTH-1:0] ex_address,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    output logic                  stall,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic                  misaligned,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_address,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

    localparam logic [4:0] ATOMIC_NO_OP = 5'd0;
    localparam logic [4:0] ATOMIC_LR    = 5'd1;
    localparam logic [4:0] ATOMIC_SC    = 5'd2;
    localparam logic [4:0] ATOMIC_SWAP  = 5'd3;
    localparam logic [4:0] ATOMIC_ADD   = 5'd4;
    localparam logic [4:0] ATOMIC_XOR   = 5'd5;
    localparam logic [4:0] ATOMIC_AND   = 5'd6;
    localparam logic [4:0] ATOMIC_OR    = 5'd7;
    localparam logic [4:0] ATOMIC_MIN   = 5'd8;
    localparam logic [4:0] ATOMIC_MAX   = 5'd9;
    localparam logic [4:0] ATOMIC_MINU  = 5'd10;
    localparam logic [4:0] ATOMIC_MAXU  = 5'd11;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;

    typedef enum logic [2:0] {
        IDLE, READ_REQ, READ_WAIT, WRITE_REQ, WRITE_WAIT, DONE
    } state_t;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  len);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (len[1:0])
            LEN_BYTE: r = len[2] ? {24'd0, b} : {{24{b[7]}}, b};
            LEN_HALF: r = len[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default:  r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] src, input logic [1:0] len);
        logic [31:0] r;
        case (len)
            LEN_BYTE: r = {4{src[7:0]}};
            LEN_HALF: r = {2{src[15:0]}};
            default:  r = src;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] lane, input logic [1:0] len);
        logic [3:0] r;
        case (len)
            LEN_BYTE: r = 4'b0001 << lane;
            LEN_HALF: r = 4'b0011 << lane;
            default:  r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] amo_calc(input logic [4:0]  op,
                                             input logic [31:0] old,
                                             input logic [31:0] src);
        logic signed [31:0] old_s;
        logic signed [31:0] src_s;
        logic        [31:0] r;
        old_s = old;
        src_s = src;
        case (op)
            ATOMIC_SWAP: r = src;
            ATOMIC_ADD:  r = old + src;
            ATOMIC_XOR:  r = old ^ src;
            ATOMIC_AND:  r = old & src;
            ATOMIC_OR:   r = old | src;
            ATOMIC_MIN:  r = (old_s < src_s) ? old : src;
            ATOMIC_MAX:  r = (old_s > src_s) ? old : src;
            ATOMIC_MINU: r = (old < src) ? old : src;
            ATOMIC_MAXU: r = (old > src) ? old : src;
            default:     r = src;
        endcase
        return r;
    endfunction

    state_t state;
    state_t next_state;

    logic                  req;
    logic                  atom_in;
    logic                  lr_in;
    logic                  sc_in;
    logic                  amo_in;
    logic                  mis_in;
    logic                  resv_hit;
    logic                  amo_q;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] src_q;
    logic [2:0]            len_q;
    logic [4:0]            atom_q;
    logic                  fault_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    logic                  resv_valid;
    logic [ADDR_WIDTH-3:0] resv_addr;

    assign atom_in  = (ex_atomic_op != ATOMIC_NO_OP);
    assign lr_in    = (ex_atomic_op == ATOMIC_LR);
    assign sc_in    = (ex_atomic_op == ATOMIC_SC);
    assign amo_in   = atom_in && !lr_in && !sc_in;
    assign req      = ex_mem_read || ex_mem_write || atom_in;
    assign resv_hit = resv_valid && (resv_addr == ex_address[ADDR_WIDTH-1:2]);
    assign amo_q    = (atom_q != ATOMIC_NO_OP) && (atom_q != ATOMIC_LR) && (atom_q != ATOMIC_SC);

    // Atomics are always word-sized, whatever op_length says.
    always_comb begin
        mis_in = 1'b0;
        if (atom_in)
            mis_in = (ex_address[1:0] != 2'b00);
        else if (ex_mem_op_length[1:0] == LEN_HALF)
            mis_in = ex_address[0];
        else if (ex_mem_op_length[1:0] != LEN_BYTE)
            mis_in = (ex_address[1:0] != 2'b00);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state    = state;
        stall         = 1'b0;
        result_valid  = 1'b0;
        misaligned    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall = 1'b1;
                    if (mis_in)
                        next_state = DONE;
                    else if (lr_in || amo_in)
                        next_state = READ_REQ;
                    else if (sc_in)
                        next_state = resv_hit ? WRITE_REQ : DONE;
                    else if (ex_mem_write)
                        next_state = WRITE_REQ;
                    else
                        next_state = READ_REQ;
                end
            end
            READ_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    next_state = READ_WAIT;
            end
            READ_WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid)
                    next_state = amo_q ? WRITE_REQ : DONE;
            end
            WRITE_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                if (mem_req_ready)
                    next_state = WRITE_WAIT;
            end
            WRITE_WAIT: begin
                stall      = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                misaligned   = fault_q;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // A pending request in IDLE must not stall while reset is held.
        if (!reset)
            stall = 1'b0;
    end

    assign mem_req_address = mem_req_valid ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_req_wdata   = mem_req_write ? wdata_q : '0;
    assign mem_req_wstrb   = mem_req_write ? wstrb_q : 4'b0000;
    assign result_data     = result_valid ? result_q : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            src_q      <= '0;
            len_q      <= 3'd0;
            atom_q     <= ATOMIC_NO_OP;
            fault_q    <= 1'b0;
            result_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'b0000;
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q   <= ex_address;
                        src_q    <= ex_store_data;
                        len_q    <= ex_mem_op_length;
                        atom_q   <= ex_atomic_op;
                        fault_q  <= mis_in;
                        result_q <= '0;
                        wdata_q  <= atom_in ? ex_store_data
                                            : store_lanes(ex_store_data, ex_mem_op_length[1:0]);
                        wstrb_q  <= atom_in ? 4'b1111
                                            : store_strobe(ex_address[1:0], ex_mem_op_length[1:0]);
                        if (!mis_in) begin
                            if (sc_in) begin
                                result_q   <= {{(DATA_WIDTH-1){1'b0}}, !resv_hit};
                                resv_valid <= 1'b0;
                            end else if ((amo_in || (!atom_in && ex_mem_write)) && resv_hit) begin
                                resv_valid <= 1'b0;
                            end
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_resp_valid) begin
                        result_q <= (atom_q == ATOMIC_NO_OP)
                                    ? load_extract(mem_resp_rdata, addr_q[1:0], len_q)
                                    : mem_resp_rdata;
                        if (amo_q)
                            wdata_q <= amo_calc(atom_q, mem_resp_rdata, src_q);
                        if (atom_q == ATOMIC_LR) begin
                            resv_valid <= 1'b1;
                            resv_addr  <= addr_q[ADDR_WIDTH-1:2];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_memory_access_unit.sv
// Bench for ex_memory_access_unit: directed scenarios plus randomized traffic against
// a byte-level memory and reservation model; the bench also plays the memory.
module tb_ex_memory_access_unit;

    localparam logic [4:0] A_NONE = 5'd0;
    localparam logic [4:0] A_LR   = 5'd1;
    localparam logic [4:0] A_SC   = 5'd2;
    localparam logic [4:0] A_SWAP = 5'd3;
    localparam logic [4:0] A_ADD  = 5'd4;
    localparam logic [4:0] A_XOR  = 5'd5;
    localparam logic [4:0] A_AND  = 5'd6;
    localparam logic [4:0] A_OR   = 5'd7;
    localparam logic [4:0] A_MIN  = 5'd8;
    localparam logic [4:0] A_MAX  = 5'd9;
    localparam logic [4:0] A_MINU = 5'd10;
    localparam logic [4:0] A_MAXU = 5'd11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_mem_op_length = 3'd0;
    logic [4:0]  ex_atomic_op = 5'd0;
    logic [31:0] ex_address = 32'd0;
    logic [31:0] ex_store_data = 32'd0;
    logic        stall, result_valid, misaligned, mem_req_valid, mem_req_write;
    logic [31:0] result_data, mem_req_address, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = 32'd0;

    ex_memory_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_op_length(ex_mem_op_length), .ex_atomic_op(ex_atomic_op),
        .ex_address(ex_address), .ex_store_data(ex_store_data),
        .stall(stall), .result_valid(result_valid), .result_data(result_data),
        .misaligned(misaligned), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_address(mem_req_address), .mem_req_wdata(mem_req_wdata),
        .mem_req_wstrb(mem_req_wstrb), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents: the DUT-visible copy and the model copy start identical.
    bit [31:0] dut_mem [bit [29:0]];
    bit [31:0] ref_mem [bit [29:0]];

    function automatic bit [31:0] seed_word(input bit [29:0] wa);
        return ({wa, 2'b01} * 32'h9E3779B1) ^ 32'hC3A51F07;
    endfunction

    function automatic bit [31:0] dut_rd(input bit [29:0] wa);
        return dut_mem.exists(wa) ? dut_mem[wa] : seed_word(wa);
    endfunction

    function automatic bit [31:0] ref_rd(input bit [29:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : seed_word(wa);
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] st);
        bit [31:0] r = old;
        for (int i = 0; i < 4; i++)
            if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic preload(input bit [31:0] addr, input bit [31:0] val);
        dut_mem[addr[31:2]] = val;
        ref_mem[addr[31:2]] = val;
    endtask

    // Memory responder
    int          force_hold = -1;
    int          force_resp = -1;
    bit          in_req = 1'b0;
    int          hold_cnt = 0;
    bit          resp_pending = 1'b0;
    int          resp_wait = 0;
    bit   [31:0] resp_data;
    logic [31:0] snap_addr, snap_wdata;
    logic [4:0]  snap_ctl;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [31:0] last_rd_addr = 32'd0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wdata = 32'd0;
    logic [3:0]  last_wstrb = 4'd0;

    initial begin
        forever begin
            @(negedge clock);
            mem_resp_valid = 1'b0;
            if (resp_pending) begin
                if (resp_wait == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = resp_data;
                    resp_pending   = 1'b0;
                end else begin
                    resp_wait--;
                end
            end
            mem_req_ready = 1'b0;
            if (reset && mem_req_valid) begin
                if (!in_req) begin
                    in_req     = 1'b1;
                    hold_cnt   = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 2));
                    snap_addr  = mem_req_address;
                    snap_wdata = mem_req_wdata;
                    snap_ctl   = {mem_req_write, mem_req_wstrb};
                    check("req_align", {30'd0, mem_req_address[1:0]}, 32'd0);
                    if (!mem_req_write) check("rd_wstrb", {28'd0, mem_req_wstrb}, 32'd0);
                end else begin
                    check("hold_addr", mem_req_address, snap_addr);
                    check("hold_wdata", mem_req_wdata, snap_wdata);
                    check("hold_ctl", {27'd0, mem_req_write, mem_req_wstrb}, {27'd0, snap_ctl});
                end
                if (hold_cnt > 0) begin
                    hold_cnt--;
                end else begin
                    mem_req_ready = 1'b1;
                    in_req        = 1'b0;
                    if (mem_req_write) begin
                        n_wr++;
                        last_wr_addr = mem_req_address;
                        last_wdata   = mem_req_wdata;
                        last_wstrb   = mem_req_wstrb;
                        dut_mem[mem_req_address[31:2]] =
                            merge(dut_rd(mem_req_address[31:2]), mem_req_wdata, mem_req_wstrb);
                    end else begin
                        n_rd++;
                        last_rd_addr = mem_req_address;
                        resp_data    = dut_rd(mem_req_address[31:2]);
                        resp_pending = 1'b1;
                        resp_wait    = (force_resp >= 0) ? force_resp : int'($urandom_range(0, 2));
                    end
                end
            end
        end
    end

    // Reference model: byte-addressed semantics and a single reservation.
    bit        m_resv = 1'b0;
    bit [29:0] m_resv_wa = 30'd0;

    task automatic model(input bit rd, input bit wr, input bit [2:0] len, input bit [4:0] atom,
                         input bit [31:0] addr, input bit [31:0] src,
                         output bit [31:0] res, output bit mis, output int nrd, output int nwr);
        bit [29:0] wa;
        int        lane, size;
        bit [31:0] old, val, mask, nv;
        wa   = addr[31:2];
        lane = int'(addr[1:0]);
        res  = 32'd0;
        mis  = 1'b0;
        nrd  = 0;
        nwr  = 0;
        if (atom != A_NONE)        size = 4;
        else if (len[1:0] == 2'd0) size = 1;
        else if (len[1:0] == 2'd1) size = 2;
        else                       size = 4;
        if ((lane % size) != 0) begin
            mis = 1'b1;
            return;
        end
        old = ref_rd(wa);
        if (atom == A_LR) begin
            res = old; nrd = 1; m_resv = 1'b1; m_resv_wa = wa;
        end else if (atom == A_SC) begin
            if (m_resv && m_resv_wa == wa) begin
                ref_mem[wa] = src; nwr = 1; res = 32'd0;
            end else begin
                res = 32'd1;
            end
            m_resv = 1'b0;
        end else if (atom != A_NONE) begin
            res = old; nrd = 1; nwr = 1;
            case (atom)
                A_SWAP:  nv = src;
                A_ADD:   nv = old + src;
                A_XOR:   nv = old ^ src;
                A_AND:   nv = old & src;
                A_OR:    nv = old | src;
                A_MIN:   nv = (int'(old) < int'(src)) ? old : src;
                A_MAX:   nv = (int'(old) > int'(src)) ? old : src;
                A_MINU:  nv = (old < src) ? old : src;
                A_MAXU:  nv = (old > src) ? old : src;
                default: nv = src;
            endcase
            ref_mem[wa] = nv;
            if (m_resv && m_resv_wa == wa) m_resv = 1'b0;
        end else if (wr) begin
            nv = old;
            for (int i = 0; i < size; i++) nv[8*(lane+i) +: 8] = src[8*i +: 8];
            ref_mem[wa] = nv; nwr = 1;
            if (m_resv && m_resv_wa == wa) m_resv = 1'b0;
        end else begin
            nrd  = 1;
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
            val  = (old >> (8*lane)) & mask;
            if (!len[2] && size < 4 && val[8*size-1]) val = val | ~mask;
            res = val;
        end
        if (rd && wr) res = res;
    endtask

    int          last_stall, last_cyc;
    logic [31:0] last_res;
    logic        last_mis;

    task automatic run_op(input string tag, input bit rd, input bit wr, input bit [2:0] len,
                          input bit [4:0] atom, input bit [31:0] addr, input bit [31:0] src);
        bit [31:0] e_res;
        bit        e_mis;
        int        e_nrd, e_nwr, rd0, wr0, cyc;
        bit        done;
        model(rd, wr, len, atom, addr, src, e_res, e_mis, e_nrd, e_nwr);
        rd0 = n_rd;
        wr0 = n_wr;
        ex_mem_read      = rd;
        ex_mem_write     = wr;
        ex_mem_op_length = len;
        ex_atomic_op     = atom;
        ex_address       = addr;
        ex_store_data    = src;
        cyc        = 0;
        done       = 1'b0;
        last_stall = 0;
        last_res   = 32'hX;
        last_mis   = 1'bX;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) check({tag, "_stall_first"}, {31'd0, stall}, 32'd1);
            if (result_valid) done = 1'b1;
            else if (stall) last_stall++;
        end
        last_cyc = cyc;
        if (!done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            last_res = result_data;
            last_mis = misaligned;
            check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
            check({tag, "_result"}, result_data, e_res);
            check({tag, "_misaligned"}, {31'd0, misaligned}, {31'd0, e_mis});
            check({tag, "_reads"}, n_rd - rd0, e_nrd);
            check({tag, "_writes"}, n_wr - wr0, e_nwr);
            if (!e_mis) check({tag, "_mem"}, dut_rd(addr[31:2]), ref_rd(addr[31:2]));
        end
        @(posedge clock);
        #1;
        if (done) check({tag, "_pulse"}, {31'd0, result_valid}, 32'd0);
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_atomic_op  = A_NONE;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {27'd0, stall, result_valid, misaligned, mem_req_valid, mem_req_write}, 32'd0);
        check({tag, "_result"}, result_data, 32'd0);
        check({tag, "_addr"}, mem_req_address, 32'd0);
        check({tag, "_wdata"}, mem_req_wdata, 32'd0);
        check({tag, "_wstrb"}, {28'd0, mem_req_wstrb}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        ex_mem_read = 1'b1;
        #12;
        check_reset_outputs("rst");
        ex_mem_read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        force_hold = 0;
        force_resp = 0;
        preload(32'h100, 32'hDEADBEEF);
        run_op("lw", 1, 0, 3'b010, A_NONE, 32'h100, 32'd0);
        check("lw_value", last_res, 32'hDEADBEEF);
        check("lw_stall_cycles", last_stall, 32'd3);
        check("lw_result_cycle", last_cyc, 32'd4);
        check("lw_addr", last_rd_addr, 32'h100);

        preload(32'h100, 32'h80FF_0000);
        run_op("lb", 1, 0, 3'b000, A_NONE, 32'h103, 32'd0);
        check("lb_value", last_res, 32'hFFFF_FF80);
        run_op("lbu", 1, 0, 3'b100, A_NONE, 32'h103, 32'd0);
        check("lbu_value", last_res, 32'h0000_0080);

        run_op("sh", 0, 1, 3'b001, A_NONE, 32'h102, 32'h1234ABCD);
        check("sh_wdata", last_wdata, 32'hABCDABCD);
        check("sh_wstrb", {28'd0, last_wstrb}, 32'h0000_000C);
        check("sh_addr", last_wr_addr, 32'h100);

        force_hold = 2;
        preload(32'h200, 32'd5);
        run_op("amoadd", 0, 0, 3'b010, A_ADD, 32'h200, 32'd7);
        check("amoadd_old", last_res, 32'd5);
        check("amoadd_wdata", last_wdata, 32'd12);
        check("amoadd_raddr", last_rd_addr, 32'h200);
        check("amoadd_waddr", last_wr_addr, 32'h200);
        force_hold = 0;

        run_op("lr1", 0, 0, 3'b010, A_LR, 32'h300, 32'd0);
        run_op("sc1", 0, 0, 3'b010, A_SC, 32'h300, 32'hCAFE0001);
        check("sc1_status", last_res, 32'd0);
        check("sc1_wdata", last_wdata, 32'hCAFE0001);
        run_op("sc2", 0, 0, 3'b010, A_SC, 32'h300, 32'h11111111);
        check("sc2_status", last_res, 32'd1);
        run_op("lr3", 0, 0, 3'b010, A_LR, 32'h300, 32'd0);
        run_op("sw3", 0, 1, 3'b010, A_NONE, 32'h300, 32'h22222222);
        run_op("sc3", 0, 0, 3'b010, A_SC, 32'h300, 32'h33333333);
        check("sc3_status", last_res, 32'd1);

        run_op("lw_mis", 1, 0, 3'b010, A_NONE, 32'h101, 32'd0);
        check("lw_mis_flag", {31'd0, last_mis}, 32'd1);
        check("lw_mis_result", last_res, 32'd0);

        // Reset while a load waits for its response.
        run_op("lr_pre", 0, 0, 3'b010, A_LR, 32'h300, 32'd0);
        force_resp       = 6;
        rd0              = n_rd;
        ex_mem_read      = 1'b1;
        ex_mem_op_length = 3'b010;
        ex_address       = 32'h400;
        for (int i = 0; i < 20 && n_rd == rd0; i++) begin
            @(negedge clock);
            #1;
        end
        check("rst_mid_accept", n_rd - rd0, 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        ex_mem_read    = 1'b0;
        resp_pending   = 1'b0;
        in_req         = 1'b0;
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        m_resv         = 1'b0;
        force_resp     = 0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        run_op("sc_after_rst", 0, 0, 3'b010, A_SC, 32'h300, 32'h44444444);
        check("sc_after_rst_status", last_res, 32'd1);
        run_op("lr_after_rst", 0, 0, 3'b010, A_LR, 32'h300, 32'd0);
        run_op("sc_after_lr", 0, 0, 3'b010, A_SC, 32'h300, 32'h55555555);
        check("sc_after_lr_status", last_res, 32'd0);

        force_hold = -1;
        force_resp = -1;
        for (int k = 0; k < 200; k++) begin
            int        cls;
            bit [2:0]  len;
            bit [4:0]  atom;
            bit [31:0] addr;
            bit        rd, wr;
            cls  = int'($urandom_range(0, 9));
            len  = 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2);
            atom = A_NONE;
            rd   = 1'b0;
            wr   = 1'b0;
            if (cls <= 2)      rd = 1'b1;
            else if (cls <= 4) wr = 1'b1;
            else if (cls == 5) atom = A_LR;
            else if (cls == 6) atom = A_SC;
            else               atom = 5'($urandom_range(3, 11));
            if (atom != A_NONE) len = 3'b010;
            addr = 32'h300 | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 4) == 0)
                addr[1:0] = 2'($urandom_range(0, 3));
            else if (len[1:0] == 2'd0)
                addr[1:0] = 2'($urandom_range(0, 3));
            else if (len[1:0] == 2'd1)
                addr[1:0] = {1'($urandom_range(0, 1)), 1'b0};
            run_op("rnd", rd, wr, len, atom, addr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
